// File: rtl/stream_pattern_gen.sv
// Counting-pattern stream generator with an optional read-stream checker.
// Define STREAM_CHECK_EN to include the checker; otherwise rd_ready and err_cnt are tied to 0.
module stream_pattern_gen #(
   parameter int CONFIG_LEN    = 2,
   parameter int CONFIG_SEED   = 3,
   parameter int CONFIG_AWIDTH = 5,
   parameter int CONFIG_DWIDTH = 32,
   parameter int STREAM_WIDTH  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CONFIG_AWIDTH-1:0] cfg_addr,
   input  logic [CONFIG_DWIDTH-1:0] cfg_data,
   input  logic                     cfg_valid,
   output logic [STREAM_WIDTH-1:0]  wr_data,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   input  logic [STREAM_WIDTH-1:0]  rd_data,
   input  logic                     rd_valid,
   output logic                     rd_ready,
   output logic                     busy,
   output logic [31:0]              sent_cnt,
   output logic [31:0]              err_cnt
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                   state_q;
   logic [CONFIG_DWIDTH-1:0] len_q;
   logic [CONFIG_DWIDTH-1:0] remaining_q;
   logic [STREAM_WIDTH-1:0]  data_q;
   logic                     wr_valid_q;
   logic [31:0]              sent_cnt_q;

   logic len_wr;
   logic seed_wr;
   logic start;
   logic beat;

   assign len_wr  = cfg_valid && (cfg_addr == CONFIG_AWIDTH'(CONFIG_LEN));
   assign seed_wr = cfg_valid && (cfg_addr == CONFIG_AWIDTH'(CONFIG_SEED));
   // A seed write only launches a run from IDLE with a non-zero length.
   assign start   = (state_q == IDLE) && seed_wr && (len_q != '0);
   assign beat    = wr_valid_q && wr_ready;

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         remaining_q <= '0;
         data_q      <= '0;
         wr_valid_q  <= 1'b0;
         sent_cnt_q  <= '0;
      end else begin
         if (len_wr) len_q <= cfg_data;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= RUN;
                  wr_valid_q  <= 1'b1;
                  data_q      <= cfg_data[STREAM_WIDTH-1:0];
                  remaining_q <= len_q;
                  sent_cnt_q  <= '0;
               end
            end
            RUN: begin
               if (beat) begin
                  data_q      <= data_q + 1'b1;
                  remaining_q <= remaining_q - 1'b1;
                  sent_cnt_q  <= sent_cnt_q + 32'd1;
                  if (remaining_q == CONFIG_DWIDTH'(1)) begin
                     state_q    <= IDLE;
                     wr_valid_q <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_data  = data_q;
   assign wr_valid = wr_valid_q;
   assign busy     = (state_q == RUN);
   assign sent_cnt = sent_cnt_q;

`ifdef STREAM_CHECK_EN
   logic [STREAM_WIDTH-1:0] expected_q;
   logic [31:0]             err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         expected_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         if (start) expected_q <= cfg_data[STREAM_WIDTH-1:0];
         else if (rd_valid) expected_q <= expected_q + 1'b1;
         // Error count sticks at all-ones rather than wrapping back to zero.
         if (rd_valid && (rd_data != expected_q) && (err_cnt_q != '1))
            err_cnt_q <= err_cnt_q + 32'd1;
      end
   end

   assign rd_ready = 1'b1;
   assign err_cnt  = err_cnt_q;
`else
   logic unused_rd;
   assign unused_rd = ^{rd_data, rd_valid};
   assign rd_ready  = 1'b0;
   assign err_cnt   = '0;
`endif

endmodule
